// File: rtl/serial_frame_tx.sv
// ----------------------------------------------------------------------------
// serial_frame_tx
//   Frames a parallel byte onto a single serial line as
//   start(0), D[7]..D[0] (MSB first), stop(1). Each bit lasts CLKS_PER_BIT
//   clocks. This block feeds the 10-bit serial-in capture register directly
//   downstream.
//
// Ports
//   clk        single clock, all state updates on posedge
//   reset      synchronous active-low reset
//   TxData     byte to send, sampled only on the accept edge
//   TxValid    producer offers a byte
//   TxReady    block can accept a byte this cycle
//   SerialOut  serial line, idles high
//   Busy       high while a frame is in flight (START..STOP)
//   FrameDone  one-cycle pulse after the stop bit completes; with
//              CLKS_PER_BIT=1 it lines up with the capture register's Pout
//
// Every output comes straight from a flop. The next-state logic computes
// the next value of each output alongside the next state.
// ----------------------------------------------------------------------------
module serial_frame_tx #(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] TxData,
    input  logic       TxValid,
    output logic       TxReady,
    output logic       SerialOut,
    output logic       Busy,
    output logic       FrameDone
);

    localparam int            CW       = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

    state_t        r_state,  w_state_nxt;
    logic [CW-1:0] r_baud,   w_baud_nxt;
    logic [2:0]    r_bitcnt, w_bitcnt_nxt;
    logic [7:0]    r_shreg,  w_shreg_nxt;
    logic          r_ser,    w_ser_nxt;
    logic          r_ready,  w_ready_nxt;
    logic          r_busy,   w_busy_nxt;
    logic          r_done,   w_done_nxt;
    logic          w_bit_end;

    // Last clock of the current bit period. With CLKS_PER_BIT=1 the counter
    // stays at 0, so every edge ends a bit.
    assign w_bit_end = (r_baud == CNT_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= S_IDLE;
            r_baud   <= '0;
            r_bitcnt <= '0;
            r_shreg  <= '0;
            r_ser    <= 1'b1;
            r_ready  <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_baud   <= w_baud_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_shreg  <= w_shreg_nxt;
            r_ser    <= w_ser_nxt;
            r_ready  <= w_ready_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_baud_nxt   = r_baud;
        w_bitcnt_nxt = r_bitcnt;
        w_shreg_nxt  = r_shreg;
        w_ser_nxt    = r_ser;
        w_ready_nxt  = r_ready;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;     // strobe: high for one cycle at most

        case (r_state)
            S_IDLE: begin
                w_baud_nxt = '0;
                if (TxValid && r_ready) begin
                    w_shreg_nxt = TxData;
                    w_state_nxt = S_START;
                    w_ser_nxt   = 1'b0;
                    w_ready_nxt = 1'b0;
                    w_busy_nxt  = 1'b1;
                end
            end

            S_START: begin
                if (w_bit_end) begin
                    w_baud_nxt   = '0;
                    w_state_nxt  = S_DATA;
                    w_bitcnt_nxt = 3'd7;
                    w_ser_nxt    = r_shreg[7];
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end

            S_DATA: begin
                if (w_bit_end) begin
                    w_baud_nxt = '0;
                    if (r_bitcnt == 3'd0) begin
                        w_state_nxt = S_STOP;
                        w_ser_nxt   = 1'b1;
                    end else begin
                        // Line reg takes the bit that becomes shreg[7]
                        // after this shift.
                        w_bitcnt_nxt = r_bitcnt - 3'd1;
                        w_shreg_nxt  = {r_shreg[6:0], 1'b0};
                        w_ser_nxt    = r_shreg[6];
                    end
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end

            S_STOP: begin
                if (w_bit_end) begin
                    w_baud_nxt  = '0;
                    w_state_nxt = S_IDLE;
                    w_ser_nxt   = 1'b1;
                    w_ready_nxt = 1'b1;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_baud_nxt = r_baud + CW'(1);
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_baud_nxt  = '0;
                w_ser_nxt   = 1'b1;
                w_ready_nxt = 1'b1;
                w_busy_nxt  = 1'b0;
            end
        endcase
    end

    assign TxReady   = r_ready;
    assign SerialOut = r_ser;
    assign Busy      = r_busy;
    assign FrameDone = r_done;

endmodule

// File: tb/tb_serial_frame_tx.sv
// ----------------------------------------------------------------------------
// tb_serial_frame_tx
//   Three instances of serial_frame_tx with CLKS_PER_BIT = 1, 2 and 4, each
//   with its own inputs. Expected line levels come from a waveform model:
//   given the byte and C, cycle k after the accept edge carries start, data
//   bit, or stop purely by arithmetic on k. A capture model rebuilds the
//   byte from one sample per bit period.
// ----------------------------------------------------------------------------
module tb_serial_frame_tx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst [3];
    logic [7:0] txd [3];
    logic       txv [3];
    logic       rdy [3];
    logic       ser [3];
    logic       bsy [3];
    logic       dn  [3];

    int n_checks = 0;
    int n_fail   = 0;

    serial_frame_tx #(.CLKS_PER_BIT(1)) dut_c1 (
        .clk(clk), .reset(rst[0]), .TxData(txd[0]), .TxValid(txv[0]),
        .TxReady(rdy[0]), .SerialOut(ser[0]), .Busy(bsy[0]), .FrameDone(dn[0]));

    serial_frame_tx #(.CLKS_PER_BIT(2)) dut_c2 (
        .clk(clk), .reset(rst[1]), .TxData(txd[1]), .TxValid(txv[1]),
        .TxReady(rdy[1]), .SerialOut(ser[1]), .Busy(bsy[1]), .FrameDone(dn[1]));

    serial_frame_tx #(.CLKS_PER_BIT(4)) dut_c4 (
        .clk(clk), .reset(rst[2]), .TxData(txd[2]), .TxValid(txv[2]),
        .TxReady(rdy[2]), .SerialOut(ser[2]), .Busy(bsy[2]), .FrameDone(dn[2]));

    function automatic int cpb(input int idx);
        case (idx)
            0:       return 1;
            1:       return 2;
            default: return 4;
        endcase
    endfunction

    // Line level in cycle k (k=1 is the cycle right after the accept edge).
    function automatic logic exp_ser(input logic [7:0] b, input int c, input int k);
        int bit_no;
        if (k <= c)     return 1'b0;
        if (k <= 9 * c) begin
            bit_no = (k - 1 - c) / c;   // 0 = D7
            return b[7 - bit_no];
        end
        return 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic chk_idle(input int idx, input string tag);
        chk($sformatf("%s c%0d ser", tag, cpb(idx)),  32'(ser[idx]), 32'd1);
        chk($sformatf("%s c%0d rdy", tag, cpb(idx)),  32'(rdy[idx]), 32'd1);
        chk($sformatf("%s c%0d busy", tag, cpb(idx)), 32'(bsy[idx]), 32'd0);
        chk($sformatf("%s c%0d done", tag, cpb(idx)), 32'(dn[idx]),  32'd0);
    endtask

    // Called just after a negedge with the instance idle (or in its
    // FrameDone cycle). Returns just after the negedge of the FrameDone
    // cycle, or after the post-reset cycle when abort_k is hit.
    //   hold    : keep TxValid high and present next_b for a back-to-back frame
    //   meddle  : wiggle TxData/TxValid while the frame is in flight
    //   abort_k : pull reset low in cycle abort_k (0 = never)
    task automatic send_frame(input int idx, input logic [7:0] b, input bit hold,
                              input logic [7:0] next_b, input bit meddle, input int abort_k);
        int         c;
        int         last;
        logic [9:0] cap;
        bit         aborted;
        c       = cpb(idx);
        last    = 10 * c + 1;
        cap     = '0;
        aborted = 1'b0;
        chk($sformatf("c%0d ready before %0h", c, b), 32'(rdy[idx]), 32'd1);
        txd[idx] = b;
        txv[idx] = 1'b1;
        for (int k = 1; k <= last; k++) begin
            @(negedge clk);
            if (!hold && !meddle) txv[idx] = 1'b0;
            chk($sformatf("c%0d %0h k%0d ser", c, b, k),  32'(ser[idx]), 32'(exp_ser(b, c, k)));
            chk($sformatf("c%0d %0h k%0d busy", c, b, k), 32'(bsy[idx]), 32'(k <= 10 * c));
            chk($sformatf("c%0d %0h k%0d rdy", c, b, k),  32'(rdy[idx]), 32'(k > 10 * c));
            chk($sformatf("c%0d %0h k%0d done", c, b, k), 32'(dn[idx]),  32'(k == last));
            if (k <= 10 * c && (k - 1) % c == 0) cap[9 - (k - 1) / c] = ser[idx];
            if (k == last) begin
                chk($sformatf("c%0d fulldata", c), 32'(cap[8:1]), 32'(b));
                chk($sformatf("c%0d start/stop", c), 32'({cap[9], cap[0]}), 32'd1);
            end
            if (meddle) begin
                if (k >= 3 && k < 10 * c) begin
                    txd[idx] = b ^ 8'hFF;
                    txv[idx] = ~txv[idx];
                end else if (k >= 10 * c) begin
                    txv[idx] = 1'b0;
                end
            end
            if (k == abort_k) begin
                rst[idx] = 1'b0;
                @(negedge clk);
                chk_idle(idx, "after abort");
                rst[idx] = 1'b1;
                aborted  = 1'b1;
                break;
            end
        end
        if (hold && !aborted) txd[idx] = next_b;
        if (!hold) txv[idx] = 1'b0;
    endtask

    initial begin
        int         idx;
        logic [7:0] b;

        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b0;
            txv[i] = 1'b1;
            txd[i] = 8'hFF;
        end
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) chk_idle(i, "reset");
        end
        for (int i = 0; i < 3; i++) begin
            rst[i] = 1'b1;
            txv[i] = 1'b0;
            txd[i] = 8'h00;
        end
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_idle(i, "post reset");

        // C=1, 0xA5
        send_frame(0, 8'hA5, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle(0, "after A5");

        // C=4, 0x3C
        send_frame(2, 8'h3C, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle(2, "after 3C");

        // Back-to-back with TxValid held, C=1
        send_frame(0, 8'h01, 1'b1, 8'h80, 1'b0, 0);
        send_frame(0, 8'h80, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle(0, "after b2b");

        // Inputs wiggle while busy, C=4
        send_frame(2, 8'h55, 1'b0, 8'h00, 1'b1, 0);
        repeat (3) begin
            @(negedge clk);
            chk_idle(2, "no extra frame");
        end

        // Reset during DATA bit 3, C=2 (cycles 9..10 after accept)
        send_frame(1, 8'hC3, 1'b0, 8'h00, 1'b0, 9);
        repeat (25) begin
            @(negedge clk);
            chk_idle(1, "aborted quiet");
        end
        send_frame(1, 8'h0F, 1'b0, 8'h00, 1'b0, 0);
        @(negedge clk);
        chk_idle(1, "after 0F");

        // Random bytes on random instances
        repeat (8) begin
            idx = int'($urandom_range(0, 2));
            b   = 8'($urandom);
            send_frame(idx, b, 1'b0, 8'h00, 1'b0, 0);
            repeat (int'($urandom_range(1, 3))) begin
                @(negedge clk);
                chk_idle(idx, "rand gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
